pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock controller for the board PLL. It drives the PLL's `reset`/`pwrdwn` inputs and consumes its `locked` output. It applies a minimum-width PLL reset, waits for lock with a timeout and retry, and qualifies lock over a stability window. It then releases a reset for the rest of the design and re-sequences on lock loss or a power-down request. It runs on the free-running 16 MHz board input clock, which also feeds the PLL's `clkin`.

## Interface
- `RST_CYCLES`, 4: cycles `pll_reset` is held per reset pulse.
- `LOCK_TIMEOUT`, 16384: cycles in WAIT_LOCK before retry (about 1 ms).
- `STABLE_CYCLES`, 256: cycles `locked` must stay continuously high before release.
- `CNT_WIDTH`, 16: width of the shared phase counter.
  - All three cycle parameters must be ≥1 and <2^CNT_WIDTH.

Ports:
- `clock`  in  1  board input clock
- `reset_n`  in  1  synchronous, active-low
- `pll_locked`  in  1  PLL LOCKED, asynchronous; 2-flop synchronized internally to `locked_s`
- `pwrdwn_req`  in  1  synchronous power-down request, level
- `pll_reset`  out  1  to PLL reset input
- `pll_pwrdwn`  out  1  to PLL pwrdwn input
- `sys_reset`  out  1  active-high reset for downstream logic; consumer re-synchronizes it into the PLL clock domains
- `ready`  out  1  equals ~`sys_reset`
- `state`  out  3  current state encoding
- `retry_count`  out  8  lock timeouts, saturating at 255
- `lock_lost`  out  1  sticky: lock dropped while in RUN

## Operation
- States: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, PWRDN=4.
- All outputs are registered Moore decodes of the state register.
  - `pll_reset`=1 in RESET and PWRDN.
  - `pll_pwrdwn`=1 in PWRDN only.
  - `sys_reset`=0 and `ready`=1 in RUN only.
- The counter clears on every state change.
- Transition priority: `reset_n` low, then `pwrdwn_req`, then the per-state rules.
  - Any state with `pwrdwn_req`=1 → PWRDN.
  - RESET: when counter == RST_CYCLES-1 → WAIT_LOCK.
  - WAIT_LOCK:
    - `locked_s`=1 → STABLE.
    - Otherwise, when counter == LOCK_TIMEOUT-1 → RESET and `retry_count`++ (saturating).
  - STABLE:
    - `locked_s`=0 → WAIT_LOCK. The timeout restarts and there is no retry increment.
    - Otherwise, when counter == STABLE_CYCLES-1 → RUN.
  - RUN: `locked_s`=0 → RESET.
  - PWRDN: stays while `pwrdwn_req`=1; on 0 → RESET.
- `lock_lost` sets on any cycle with state RUN and `locked_s`=0, including when `pwrdwn_req` wins that cycle.
- `lock_lost` and `retry_count` clear only on `reset_n`.

## Timing
- Reset values (edge with `reset_n`=0):
  - state=RESET, counter=0, sync flops=0.
  - `pll_reset`=1, `pll_pwrdwn`=0, `sys_reset`=1, `ready`=0.
  - `retry_count`=0, `lock_lost`=0.
- `reset_n` low mid-operation takes effect at the next edge from any state.
- Dwell times:
  - `pll_reset` pulse is exactly RST_CYCLES cycles.
  - WAIT_LOCK without lock lasts exactly LOCK_TIMEOUT cycles.
- Lock rise: with `pll_locked` first sampled high at edge e0 and held, STABLE is entered at e0+2 and RUN at e0+2+STABLE_CYCLES.
- Lock fall: with `pll_locked` first sampled low at e0 while in RUN, state=RESET and `sys_reset`=1 at e0+2.
- `pwrdwn_req` sampled high at edge e moves to PWRDN at e+1.
- After `pwrdwn_req` falls, a full RESET/WAIT_LOCK/STABLE sequence is always replayed.
- A lock glitch shorter than 1 cycle may be missed. Any glitch of 1 cycle or more seen on `locked_s` in STABLE restarts qualification.

## Configuration
- `PLL_LOCK_SEQ_TIMEOUT_EN` defined: the WAIT_LOCK timeout and retry are compiled in, as described above.
- `PLL_LOCK_SEQ_TIMEOUT_EN` undefined:
  - WAIT_LOCK waits indefinitely for `locked_s`.
  - `retry_count` is constant 0.
  - All other behaviour is identical.

## Test plan
- Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=8, STABLE_CYCLES=16, macro defined unless noted.
1. Reset exit: `reset_n`=0 for 3 cycles then 1, `pll_locked`=0 → `pll_reset`=1 for exactly 4 cycles, then `state`=1, `sys_reset`=1.
2. Lock up: `pll_locked`→1 three cycles into WAIT_LOCK and held → `state`=2 at e0+2, `ready`=1 and `sys_reset`=0 at e0+18.
3. Glitch in STABLE: `pll_locked`=0 for 2 cycles at STABLE count 10 → `state`=1, `retry_count` unchanged; after relock, `ready` rises after the full 16 cycles.
4. Timeout: `pll_locked` held 0 → `pll_reset` reasserts every 12 cycles, `retry_count` increments per timeout and saturates at 255 after 300 timeouts. With the macro undefined: `state` stays 1 and `retry_count`=0.
5. Lock loss in RUN: `pll_locked`→0 → two edges later `state`=0, `sys_reset`=1, `pll_reset`=1, `lock_lost`=1; `lock_lost` stays 1 after relock until `reset_n`.
6. Power-down and mid-op reset: `pwrdwn_req`=1 for 5 cycles in RUN → `pll_pwrdwn`=1 and `pll_reset`=1 for 5 cycles, then 4 RESET cycles. `reset_n`=0 during the following WAIT_LOCK → all outputs take reset values at the next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Reset and lock controller for the board PLL. Runs on the free-running board
// input clock (the same clock that feeds the PLL clkin). It pulses the PLL
// reset for a minimum width and then waits for LOCKED. An optional timeout
// triggers a retry. Lock must then hold for a stability window before the
// downstream reset is released. Lock loss or a power-down request makes the
// controller re-sequence from the start.
//
// Optional feature macro: PLL_LOCK_SEQ_TIMEOUT_EN
//   defined   : WAIT_LOCK times out after LOCK_TIMEOUT cycles, returns to
//               RESET and bumps retry_count (saturating at 255).
//   undefined : WAIT_LOCK waits indefinitely; retry_count is constant 0.
//
// Parameters (each cycle count must be >= 1 and < 2**CNT_WIDTH):
//   RST_CYCLES    cycles pll_reset is held per reset pulse
//   LOCK_TIMEOUT  cycles spent in WAIT_LOCK before a retry
//   STABLE_CYCLES cycles locked must stay high before release
//   CNT_WIDTH     width of the shared phase counter
//
// Ports:
//   clock        in   board input clock
//   reset_n      in   synchronous active-low reset
//   pll_locked   in   PLL LOCKED (asynchronous, 2-flop synchronized here)
//   pwrdwn_req   in   synchronous power-down request (level)
//   pll_reset    out  PLL reset input (high in RESET and PWRDN)
//   pll_pwrdwn   out  PLL power-down input (high in PWRDN)
//   sys_reset    out  active-high downstream reset (low only in RUN)
//   ready        out  inverse of sys_reset
//   state        out  current state (RESET=0 WAIT_LOCK=1 STABLE=2 RUN=3 PWRDN=4)
//   retry_count  out  number of lock timeouts, saturating at 255
//   lock_lost    out  sticky flag: lock dropped while in RUN
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 16384,
    parameter int STABLE_CYCLES = 256,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       pwrdwn_req,
    output logic       pll_reset,
    output logic       pll_pwrdwn,
    output logic       sys_reset,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] retry_count,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_PWRDN     = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so a dwell of
    // N cycles ends when the counter reads N-1.
    localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    // LOCKED comes from the PLL with no relationship to this clock.
    logic [1:0] sync_d, sync_q;
    logic       locked_s;

    assign sync_d   = {sync_q[0], pll_locked};
    assign locked_s = sync_q[1];

    // The power-down request is captured once before the FSM acts on it, so a
    // request seen at one edge moves the state at the following edge.
    logic pwrdwn_d, pwrdwn_q;

    assign pwrdwn_d = pwrdwn_req;

    // -------------------------------------------------------------------------
    // State, phase counter and status registers
    // -------------------------------------------------------------------------
    state_t               state_d, state_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 lock_lost_d, lock_lost_q;

    // Output flops, loaded from the next-state decode so they change on the
    // same edge as the state register and never glitch.
    logic pll_reset_d, pll_reset_q;
    logic pll_pwrdwn_d, pll_pwrdwn_q;
    logic sys_reset_d, sys_reset_q;

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
    logic [7:0] retry_d, retry_q;
    logic       timeout_hit;

    // Power-down outranks the timeout, so a timeout that coincides with a
    // power-down request is not counted as a retry.
    assign timeout_hit = (state_q == ST_WAIT_LOCK) && !pwrdwn_q && !locked_s &&
                         (cnt_q == TIMEOUT_LAST);
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (pwrdwn_q) begin
            state_d = ST_PWRDN;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_d = ST_RESET;
                    end
`endif
                end
                ST_STABLE: begin
                    // Any dropout restarts qualification from WAIT_LOCK with a
                    // fresh timeout; it is not counted as a retry.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET;
                    end
                end
                ST_PWRDN: begin
                    // Only reached with the request deasserted; always replay
                    // the full sequence.
                    state_d = ST_RESET;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Phase counter: zero on every state change, counts only in the timed
    // states.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            case (state_q)
                ST_RESET, ST_STABLE: begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                ST_WAIT_LOCK: begin
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_ONE;
`else
                    // No timeout: park the counter instead of letting it wrap.
                    cnt_d = (cnt_q == TIMEOUT_LAST) ? cnt_q : cnt_q + CNT_ONE;
`endif
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Status and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // Set whenever RUN sees lock low, even if power-down wins that cycle.
        lock_lost_d  = lock_lost_q | ((state_q == ST_RUN) && !locked_s);

        pll_reset_d  = (state_d == ST_RESET) || (state_d == ST_PWRDN);
        pll_pwrdwn_d = (state_d == ST_PWRDN);
        sys_reset_d  = (state_d != ST_RUN);
    end

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
    always_comb begin
        retry_d = retry_q;
        if (timeout_hit && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q       <= '0;
            pwrdwn_q     <= 1'b0;
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            lock_lost_q  <= 1'b0;
            pll_reset_q  <= 1'b1;
            pll_pwrdwn_q <= 1'b0;
            sys_reset_q  <= 1'b1;
        end else begin
            sync_q       <= sync_d;
            pwrdwn_q     <= pwrdwn_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_lost_q  <= lock_lost_d;
            pll_reset_q  <= pll_reset_d;
            pll_pwrdwn_q <= pll_pwrdwn_d;
            sys_reset_q  <= sys_reset_d;
        end
    end

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retry_q <= 8'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_count = retry_q;
`else
    assign retry_count = 8'd0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign state      = state_q;
    assign pll_reset  = pll_reset_q;
    assign pll_pwrdwn = pll_pwrdwn_q;
    assign sys_reset  = sys_reset_q;
    assign ready      = ~sys_reset_q;
    assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Scoreboard bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=8,
// STABLE_CYCLES=16. Each scenario task pushes the expected per-cycle output
// vector for its stimulus. It then steps the clock and pops one expectation
// per edge, comparing the outputs 1 time unit after the rising edge.
// Timeout expectations follow PLL_LOCK_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PWRDN  = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pwrdwn_req;
    logic       pll_reset;
    logic       pll_pwrdwn;
    logic       sys_reset;
    logic       ready;
    logic [2:0] state;
    logic [7:0] retry_count;
    logic       lock_lost;

    int checks   = 0;
    int failures = 0;

    // Expected vector: {state, pll_reset, pll_pwrdwn, sys_reset, ready, lock_lost, retry_count}
    logic [15:0] exp_q[$];
    logic [7:0]  exp_retry;
    logic        exp_ll;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (8),
        .STABLE_CYCLES(16),
        .CNT_WIDTH    (16)
    ) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .pwrdwn_req (pwrdwn_req),
        .pll_reset  (pll_reset),
        .pll_pwrdwn (pll_pwrdwn),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .state      (state),
        .retry_count(retry_count),
        .lock_lost  (lock_lost)
    );

    // Output table for a state, using the currently expected sticky/retry values.
    function automatic logic [15:0] mk(input logic [2:0] st);
        logic pr, pd, sr, rdy;
        pr  = (st == S_RESET) || (st == S_PWRDN);
        pd  = (st == S_PWRDN);
        sr  = (st != S_RUN);
        rdy = (st == S_RUN);
        return {st, pr, pd, sr, rdy, exp_ll, exp_retry};
    endfunction

    function automatic logic [15:0] observed();
        return {state, pll_reset, pll_pwrdwn, sys_reset, ready, lock_lost, retry_count};
    endfunction

    function automatic string fmt(input logic [15:0] v);
        return $sformatf("state=%0d pll_reset=%b pll_pwrdwn=%b sys_reset=%b ready=%b lock_lost=%b retry=%0d",
                         v[15:13], v[12], v[11], v[10], v[9], v[8], v[7:0]);
    endfunction

    function automatic void push_n(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(st));
    endfunction

    // 1. Reset held 3 edges, then exactly 4 RESET cycles before WAIT_LOCK.
    task automatic test_reset();
        logic [15:0] got, exp;
        int n;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        pwrdwn_req = 1'b0;
        exp_retry  = 8'd0;
        exp_ll     = 1'b0;
        push_n(S_RESET, 3);
        push_n(S_RESET, 3);
        push_n(S_WAIT, 1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_exit c=%0d got %s expected %s", c, fmt(got), fmt(exp));
            end
            if (c == 3) reset_n = 1'b1;
        end
        $display("test_reset: %0d cycles compared", n);
    endtask

    // 2. Lock rises 3 cycles into WAIT_LOCK: STABLE at e0+2, RUN at e0+18.
    task automatic test_lock_up();
        logic [15:0] got, exp;
        int n;
        push_n(S_WAIT, 2);
        push_n(S_WAIT, 2);
        push_n(S_STABLE, 16);
        push_n(S_RUN, 1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL lock_up c=%0d got %s expected %s", c, fmt(got), fmt(exp));
            end
            if (c == 2) pll_locked = 1'b1;
        end
        $display("test_lock_up: %0d cycles compared", n);
    endtask

    // 5. Lock loss in RUN: RESET and lock_lost two edges later, then relock.
    task automatic test_lock_loss();
        logic [15:0] got, exp;
        int n;
        pll_locked = 1'b0;
        push_n(S_RUN, 2);
        exp_ll = 1'b1;
        push_n(S_RESET, 4);
        push_n(S_WAIT, 1);
        push_n(S_STABLE, 1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL lock_loss c=%0d got %s expected %s", c, fmt(got), fmt(exp));
            end
            if (c == 3) pll_locked = 1'b1;
        end
        $display("test_lock_loss: %0d cycles compared", n);
    endtask

    // 3. Two-cycle dropout at STABLE count 10: back to WAIT_LOCK, full requal.
    task automatic test_glitch();
        logic [15:0] got, exp;
        int n;
        push_n(S_STABLE, 12);
        push_n(S_WAIT, 2);
        push_n(S_STABLE, 16);
        push_n(S_RUN, 1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL glitch c=%0d got %s expected %s", c, fmt(got), fmt(exp));
            end
            if (c == 10) pll_locked = 1'b0;
            if (c == 12) pll_locked = 1'b1;
        end
        $display("test_glitch: %0d cycles compared", n);
    endtask

    // 6a. Power-down for 5 cycles from RUN, then a full replay starting in RESET.
    //     Lock is also removed so the following timeout test starts unlocked.
    task automatic test_pwrdn();
        logic [15:0] got, exp;
        int n;
        pwrdwn_req = 1'b1;
        pll_locked = 1'b0;
        push_n(S_RUN, 1);
        push_n(S_PWRDN, 5);
        push_n(S_RESET, 4);
        push_n(S_WAIT, 1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pwrdn c=%0d got %s expected %s", c, fmt(got), fmt(exp));
            end
            if (c == 5) pwrdwn_req = 1'b0;
        end
        $display("test_pwrdn: %0d cycles compared", n);
    endtask

    // 4. No lock: 8 WAIT_LOCK + 4 RESET per retry, retry_count saturating.
    task automatic test_timeout();
        logic [15:0] got, exp;
        for (int k = 0; k < 300; k++) begin
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
            push_n(S_WAIT, 7);
            if (exp_retry != 8'hFF) exp_retry = exp_retry + 8'd1;
            push_n(S_RESET, 4);
            push_n(S_WAIT, 1);
`else
            push_n(S_WAIT, 12);
`endif
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                got = observed();
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL timeout k=%0d c=%0d got %s expected %s", k, c, fmt(got), fmt(exp));
                end
            end
        end
        checks++;
        if (retry_count !== exp_retry) begin
            failures++;
            $display("FAIL retry_sat got retry_count=%0d expected %0d", retry_count, exp_retry);
        end
        $display("test_timeout: 300 periods, retry_count=%0d", retry_count);
    endtask

    // 6b. reset_n low in the middle of WAIT_LOCK: reset values at the next edge.
    task automatic test_midop_reset();
        logic [15:0] got, exp;
        int n;
        push_n(S_WAIT, 3);
        exp_retry = 8'd0;
        exp_ll    = 1'b0;
        push_n(S_RESET, 1);
        push_n(S_RESET, 3);
        push_n(S_WAIT, 1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL midop_reset c=%0d got %s expected %s", c, fmt(got), fmt(exp));
            end
            if (c == 3) reset_n = 1'b0;
            if (c == 4) reset_n = 1'b1;
        end
        $display("test_midop_reset: %0d cycles compared", n);
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_lock_loss();
        test_glitch();
        test_pwrdn();
        test_timeout();
        test_midop_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d leftover entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
